// File: rtl/sp_ram_arb2.sv
// sp_ram_arb2: two-master arbiter in front of the single-port, banked RAM wrapper.
//
// Port 0 (core data side) and port 1 (debug/DMA side) share one RAM port.
// The grant is combinational, in the same cycle as the request. The response
// (rvalid) follows one cycle after the grant and goes to the port that owned
// the access.
//
// Arbitration modes:
//   FIXED_PRIO = 0 : round-robin. The pointer moves to the loser on every grant.
//   FIXED_PRIO = 1 : port 0 wins, unless port 1 has been denied MAX_WAIT cycles in a row.
//
// Ports:
//   clk, rstn_i                  clock, asynchronous active-low reset
//   pX_req_i / pX_gnt_o          request / combinational grant, X = 0, 1
//   pX_addr_i, pX_we_i,          access attributes; held stable until granted
//   pX_be_i, pX_wdata_i
//   pX_rvalid_o / pX_rdata_o     response valid one cycle after grant; rdata = ram_rdata_i
//   ram_*                        RAM wrapper port (ram_rdata_i arrives one cycle after ram_en_o)
//   conflict_cnt_o               saturating count of cycles where both ports requested
//   p1_stall_cnt_o               saturating count of cycles where port 1 requested but was not granted
//   clr_cnt_i                    synchronous clear of both counters; overrides increment
module sp_ram_arb2 #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn_i,

  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

  output logic [CNT_WIDTH-1:0]    conflict_cnt_o,
  output logic [CNT_WIDTH-1:0]    p1_stall_cnt_o,
  input  logic                    clr_cnt_i
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic                 rr_ptr;      // 0: port 0 wins the next tie, 1: port 1 wins
  logic [7:0]           wait_cnt;
  logic [7:0]           wait_nxt;
  logic                 both;
  logic                 pick1;
  logic                 sel1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 vld_p1;
  logic                 owner_p1;
  logic [CNT_WIDTH-1:0] conflict_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // ---- stage p0: combinational arbitration and RAM request ----
  always_comb begin
    both = p0_req_i & p1_req_i;
    if (FIXED_PRIO != 0) begin
      pick1 = (wait_cnt >= MAX_WAIT_C);
    end else begin
      pick1 = rr_ptr;
    end
    sel1 = p1_req_i & (~p0_req_i | pick1);
    // Gating the grants with rstn_i keeps the RAM quiet while reset is held.
    gnt1 = rstn_i & sel1;
    gnt0 = rstn_i & p0_req_i & ~sel1;
  end

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;
  assign ram_en_o = gnt0 | gnt1;

  always_comb begin
    ram_addr_o  = p0_addr_i;
    ram_wdata_o = p0_wdata_i;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    if (gnt1) begin
      ram_addr_o  = p1_addr_i;
      ram_wdata_o = p1_wdata_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = p1_be_i;
    end else if (gnt0) begin
      ram_we_o = p0_we_i;
      ram_be_o = p0_be_i;
    end
  end

  always_comb begin
    wait_nxt = 8'd0;
    if ((FIXED_PRIO != 0) && p1_req_i && !gnt1) begin
      wait_nxt = (wait_cnt >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr       <= 1'b0;
      wait_cnt     <= 8'd0;
      vld_p1       <= 1'b0;
      owner_p1     <= 1'b0;
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (gnt0) begin
        rr_ptr <= 1'b1;
      end else if (gnt1) begin
        rr_ptr <= 1'b0;
      end
      wait_cnt <= wait_nxt;
      vld_p1   <= ram_en_o;
      owner_p1 <= gnt1;
      if (clr_cnt_i) begin
        conflict_cnt <= '0;
        stall_cnt    <= '0;
      end else begin
        if (both) begin
          conflict_cnt <= sat_inc(conflict_cnt);
        end
        if (p1_req_i && !gnt1) begin
          stall_cnt <= sat_inc(stall_cnt);
        end
      end
    end
  end

  // ---- stage p1: response routed to the owner of the previous access ----
  assign p0_rvalid_o    = vld_p1 & ~owner_p1;
  assign p1_rvalid_o    = vld_p1 &  owner_p1;
  assign p0_rdata_o     = ram_rdata_i;
  assign p1_rdata_o     = ram_rdata_i;
  assign conflict_cnt_o = conflict_cnt;
  assign p1_stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_sp_ram_arb2.sv
module tb_sp_ram_arb2;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin instance with 4-bit counters
  logic          a_p0_req, a_p0_we, a_p0_gnt, a_p0_rvalid;
  logic [AW-1:0] a_p0_addr;
  logic [BW-1:0] a_p0_be;
  logic [DW-1:0] a_p0_wdata, a_p0_rdata;
  logic          a_p1_req, a_p1_we, a_p1_gnt, a_p1_rvalid;
  logic [AW-1:0] a_p1_addr;
  logic [BW-1:0] a_p1_be;
  logic [DW-1:0] a_p1_wdata, a_p1_rdata;
  logic          a_ram_en, a_ram_we;
  logic [AW-1:0] a_ram_addr;
  logic [BW-1:0] a_ram_be;
  logic [DW-1:0] a_ram_wdata, a_ram_rdata;
  logic [3:0]    a_conflict, a_stall;
  logic          a_clr;

  sp_ram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0), .MAX_WAIT(8), .CNT_WIDTH(4)) u_rr (
    .clk(clk), .rstn_i(rstn),
    .p0_req_i(a_p0_req), .p0_gnt_o(a_p0_gnt), .p0_addr_i(a_p0_addr), .p0_we_i(a_p0_we),
    .p0_be_i(a_p0_be), .p0_wdata_i(a_p0_wdata), .p0_rvalid_o(a_p0_rvalid), .p0_rdata_o(a_p0_rdata),
    .p1_req_i(a_p1_req), .p1_gnt_o(a_p1_gnt), .p1_addr_i(a_p1_addr), .p1_we_i(a_p1_we),
    .p1_be_i(a_p1_be), .p1_wdata_i(a_p1_wdata), .p1_rvalid_o(a_p1_rvalid), .p1_rdata_o(a_p1_rdata),
    .ram_en_o(a_ram_en), .ram_addr_o(a_ram_addr), .ram_we_o(a_ram_we), .ram_be_o(a_ram_be),
    .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata),
    .conflict_cnt_o(a_conflict), .p1_stall_cnt_o(a_stall), .clr_cnt_i(a_clr)
  );

  // Fixed-priority instance, MAX_WAIT = 4
  logic          b_p0_req, b_p0_gnt, b_p0_rvalid;
  logic          b_p1_req, b_p1_gnt, b_p1_rvalid;
  logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_ram_wdata;
  logic          b_ram_en, b_ram_we;
  logic [AW-1:0] b_ram_addr;
  logic [BW-1:0] b_ram_be;
  logic [15:0]   b_conflict, b_stall;

  sp_ram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1), .MAX_WAIT(4), .CNT_WIDTH(16)) u_fp (
    .clk(clk), .rstn_i(rstn),
    .p0_req_i(b_p0_req), .p0_gnt_o(b_p0_gnt), .p0_addr_i(15'h0100), .p0_we_i(1'b0),
    .p0_be_i(4'hF), .p0_wdata_i(32'h0), .p0_rvalid_o(b_p0_rvalid), .p0_rdata_o(b_p0_rdata),
    .p1_req_i(b_p1_req), .p1_gnt_o(b_p1_gnt), .p1_addr_i(15'h4100), .p1_we_i(1'b0),
    .p1_be_i(4'hF), .p1_wdata_i(32'h0), .p1_rvalid_o(b_p1_rvalid), .p1_rdata_o(b_p1_rdata),
    .ram_en_o(b_ram_en), .ram_addr_o(b_ram_addr), .ram_we_o(b_ram_we), .ram_be_o(b_ram_be),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(32'h0),
    .conflict_cnt_o(b_conflict), .p1_stall_cnt_o(b_stall), .clr_cnt_i(1'b0)
  );

  // Behavioural RAM behind the round-robin instance; unwritten words hold init_val()
  function automatic logic [DW-1:0] init_val(input int w);
    return 32'h5A5A0000 ^ w;
  endfunction

  logic [DW-1:0] mem [int];
  always @(posedge clk) begin
    int w;
    logic [DW-1:0] cur;
    if (a_ram_en) begin
      w   = int'(a_ram_addr[AW-1:2]);
      cur = mem.exists(w) ? mem[w] : init_val(w);
      a_ram_rdata <= cur;
      if (a_ram_we) begin
        for (int b = 0; b < BW; b++) if (a_ram_be[b]) cur[8*b +: 8] = a_ram_wdata[8*b +: 8];
        mem[w] = cur;
      end
    end
  end

  // Scoreboard
  typedef struct {
    bit            port;
    bit            we;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;
  rsp_t          sbq[$];
  logic [DW-1:0] shadow [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    int w = int'(a[AW-1:2]);
    return shadow.exists(w) ? shadow[w] : init_val(w);
  endfunction

  task automatic push_rsp(input bit port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input bit rsp);
    rsp_t e;
    e.port = port;
    e.we   = we;
    e.data = we ? 'x : exp_rd(addr);
    e.due  = cyc + 1;
    if (we) shadow[int'(addr[AW-1:2])] = wd;
    if (rsp) sbq.push_back(e);
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_p0_req = req; a_p0_we = we; a_p0_addr = addr; a_p0_be = 4'hF; a_p0_wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_p1_req = req; a_p1_we = we; a_p1_addr = addr; a_p1_be = 4'hF; a_p1_wdata = wd;
  endtask

  task automatic rr_step(input logic eg0, input logic eg1, input bit rsp);
    @(negedge clk);
    chk("rr_gnt0", a_p0_gnt, eg0);
    chk("rr_gnt1", a_p1_gnt, eg1);
    chk("rr_ram_en", a_ram_en, eg0 | eg1);
    if (eg0) begin
      chk("rr_ram_addr_p0", a_ram_addr, a_p0_addr);
      chk("rr_ram_we_p0", a_ram_we, a_p0_we);
      push_rsp(1'b0, a_p0_we, a_p0_addr, a_p0_wdata, rsp);
    end else if (eg1) begin
      chk("rr_ram_addr_p1", a_ram_addr, a_p1_addr);
      chk("rr_ram_we_p1", a_ram_we, a_p1_we);
      chk("rr_ram_wdata_p1", a_ram_wdata, a_p1_wdata);
      push_rsp(1'b1, a_p1_we, a_p1_addr, a_p1_wdata, rsp);
    end else begin
      chk("rr_idle_we", a_ram_we, 1'b0);
      chk("rr_idle_be", a_ram_be, 4'h0);
      chk("rr_idle_addr", a_ram_addr, a_p0_addr);
    end
    @(posedge clk);
    #1;
  endtask

  logic fp_prev0 = 1'b0;
  logic fp_prev1 = 1'b0;
  task automatic fp_step(input logic eg0, input logic eg1);
    @(negedge clk);
    chk("fp_gnt0", b_p0_gnt, eg0);
    chk("fp_gnt1", b_p1_gnt, eg1);
    chk("fp_rvalid0", b_p0_rvalid, fp_prev0);
    chk("fp_rvalid1", b_p1_rvalid, fp_prev1);
    fp_prev0 = eg0;
    fp_prev1 = eg1;
    @(posedge clk);
    #1;
  endtask

  // Response monitor and grant invariants
  always @(negedge clk) begin
    rsp_t e;
    chk("a_gnt_onehot", a_p0_gnt & a_p1_gnt, 1'b0);
    chk("a_gnt0_no_req", a_p0_gnt & ~a_p0_req, 1'b0);
    chk("a_gnt1_no_req", a_p1_gnt & ~a_p1_req, 1'b0);
    chk("b_gnt_onehot", b_p0_gnt & b_p1_gnt, 1'b0);
    if (a_p0_rvalid | a_p1_rvalid) begin
      if (sbq.size() == 0) begin
        chk("a_spurious_rvalid", {a_p1_rvalid, a_p0_rvalid}, 2'b00);
      end else begin
        e = sbq.pop_front();
        chk("a_rsp_port", {a_p1_rvalid, a_p0_rvalid}, e.port ? 2'b10 : 2'b01);
        chk("a_rsp_cycle", cyc, e.due);
        if (!e.we) chk("a_rsp_data", e.port ? a_p1_rdata : a_p0_rdata, e.data);
      end
    end
    if (sbq.size() > 0) begin
      checks++;
      assert (sbq[0].due >= cyc) else begin
        errors++;
        $error("FAIL a_rsp_missing: observed no rvalid by cycle %0d, expected at cycle %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] p1pat;
    int w, fc, fs;
    logic e0, e1;

    rstn = 1'b0;
    a_clr = 1'b0;
    b_p0_req = 1'b1;
    b_p1_req = 1'b0;
    set_p0(1'b1, 1'b0, 15'h0010, 32'h0);
    set_p1(1'b0, 1'b0, 15'h0000, 32'h0);

    // Reset: grants and ram_en forced low despite a pending request
    @(negedge clk);
    chk("rst_gnt0", a_p0_gnt, 1'b0);
    chk("rst_ram_en", a_ram_en, 1'b0);
    chk("rst_fp_gnt0", b_p0_gnt, 1'b0);
    chk("rst_rvalid", {a_p0_rvalid, a_p1_rvalid}, 2'b00);
    chk("rst_conflict", a_conflict, 4'h0);
    chk("rst_stall", a_stall, 4'h0);
    set_p0(1'b0, 1'b0, 15'h0010, 32'h0);
    b_p0_req = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single port 0 write then read back, then port 1 read of the same word
    set_p0(1'b1, 1'b1, 15'h0010, 32'hDEADBEEF);
    rr_step(1'b1, 1'b0, 1'b1);
    set_p0(1'b1, 1'b0, 15'h0010, 32'h0);
    rr_step(1'b1, 1'b0, 1'b1);
    set_p0(1'b0, 1'b0, 15'h0010, 32'h0);
    rr_step(1'b0, 1'b0, 1'b1);
    set_p1(1'b1, 1'b0, 15'h0010, 32'h0);
    rr_step(1'b0, 1'b1, 1'b1);
    set_p1(1'b0, 1'b0, 15'h0000, 32'h0);
    rr_step(1'b0, 1'b0, 1'b1);

    // Round-robin: both ports reading for 6 cycles
    set_p0(1'b1, 1'b0, 15'h0020, 32'h0);
    set_p1(1'b1, 1'b0, 15'h0040, 32'h0);
    for (int i = 0; i < 6; i++) rr_step(i % 2 == 0, i % 2 == 1, 1'b1);
    set_p0(1'b0, 1'b0, 15'h0020, 32'h0);
    set_p1(1'b0, 1'b0, 15'h0040, 32'h0);
    rr_step(1'b0, 1'b0, 1'b1);
    chk("rr6_conflict", a_conflict, 4'd6);
    chk("rr6_stall", a_stall, 4'd3);

    // Bank crossing: lower-bank and upper-bank writes, then read back
    set_p0(1'b1, 1'b1, 15'h0004, 32'h11112222);
    set_p1(1'b1, 1'b1, 15'h4004, 32'h33334444);
    rr_step(1'b1, 1'b0, 1'b1);
    set_p0(1'b0, 1'b0, 15'h0004, 32'h0);
    rr_step(1'b0, 1'b1, 1'b1);
    set_p0(1'b1, 1'b0, 15'h0004, 32'h0);
    set_p1(1'b1, 1'b0, 15'h4004, 32'h0);
    rr_step(1'b1, 1'b0, 1'b1);
    set_p0(1'b0, 1'b0, 15'h0004, 32'h0);
    rr_step(1'b0, 1'b1, 1'b1);
    set_p1(1'b0, 1'b0, 15'h4004, 32'h0);
    rr_step(1'b0, 1'b0, 1'b1);
    chk("bank_conflict", a_conflict, 4'd8);
    chk("bank_stall", a_stall, 4'd5);

    // Counter clear, saturation, and clear taking priority over a conflict
    a_clr = 1'b1;
    rr_step(1'b0, 1'b0, 1'b1);
    a_clr = 1'b0;
    chk("clr_conflict", a_conflict, 4'd0);
    chk("clr_stall", a_stall, 4'd0);
    set_p0(1'b1, 1'b0, 15'h0100, 32'h0);
    set_p1(1'b1, 1'b0, 15'h0200, 32'h0);
    for (int i = 0; i < 20; i++) rr_step(i % 2 == 0, i % 2 == 1, 1'b1);
    chk("sat_conflict", a_conflict, 4'd15);
    chk("sat_stall", a_stall, 4'd10);
    a_clr = 1'b1;
    rr_step(1'b1, 1'b0, 1'b1);
    a_clr = 1'b0;
    chk("clrprio_conflict", a_conflict, 4'd0);
    chk("clrprio_stall", a_stall, 4'd0);
    rr_step(1'b0, 1'b1, 1'b1);
    chk("post_clr_conflict", a_conflict, 4'd1);
    chk("post_clr_stall", a_stall, 4'd0);
    set_p0(1'b0, 1'b0, 15'h0100, 32'h0);
    set_p1(1'b0, 1'b0, 15'h0200, 32'h0);
    rr_step(1'b0, 1'b0, 1'b1);

    // Reset the cycle after a port 1 read grant: its rvalid is dropped at once
    set_p1(1'b1, 1'b0, 15'h0040, 32'h0);
    rr_step(1'b0, 1'b1, 1'b0);
    set_p1(1'b0, 1'b0, 15'h0040, 32'h0);
    rstn = 1'b0;
    #1;
    chk("rst_drop_p1_rvalid", a_p1_rvalid, 1'b0);
    @(negedge clk);
    chk("rst_mid_conflict", a_conflict, 4'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    // Port 0 grant leaves the pointer at port 1; reset must bring it back to port 0
    set_p0(1'b1, 1'b0, 15'h0020, 32'h0);
    rr_step(1'b1, 1'b0, 1'b0);
    set_p0(1'b0, 1'b0, 15'h0020, 32'h0);
    rstn = 1'b0;
    #1;
    chk("rst_drop_p0_rvalid", a_p0_rvalid, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rr_step(1'b0, 1'b0, 1'b1);
    set_p0(1'b1, 1'b0, 15'h0020, 32'h0);
    set_p1(1'b1, 1'b0, 15'h0040, 32'h0);
    rr_step(1'b1, 1'b0, 1'b1);
    set_p0(1'b0, 1'b0, 15'h0020, 32'h0);
    set_p1(1'b0, 1'b0, 15'h0040, 32'h0);
    rr_step(1'b0, 1'b0, 1'b1);
    chk("rst_rel_stall", a_stall, 4'd1);

    // Fixed priority with MAX_WAIT = 4: port 0 always requests, port 1 per pattern
    p1pat = 19'b1111111111_11_0_111111;
    w = 0;
    fc = 0;
    fs = 0;
    b_p0_req = 1'b1;
    for (int i = 18; i >= 0; i--) begin
      b_p1_req = p1pat[i];
      e1 = b_p1_req && (w >= 4);
      e0 = !e1;
      if (b_p1_req) fc++;
      if (b_p1_req && !e1) begin
        fs++;
        w = (w >= 4) ? 4 : w + 1;
      end else begin
        w = 0;
      end
      fp_step(e0, e1);
    end
    b_p0_req = 1'b0;
    b_p1_req = 1'b0;
    fp_step(1'b0, 1'b0);
    chk("fp_conflict", b_conflict, 32'(fc));
    chk("fp_stall", b_stall, 32'(fs));

    rr_step(1'b0, 1'b0, 1'b1);
    rr_step(1'b0, 1'b0, 1'b1);
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_arb2.md
Name: sp_ram_arb2

Overview:
- Two-master arbiter placed in front of the single-port, banked data/instruction RAM wrapper.
- Shares that one RAM port between requester port 0 (core data side) and requester port 1 (debug/DMA side) using req/gnt/rvalid handshakes.
- Supports round-robin or fixed-priority arbitration, with starvation protection in fixed-priority mode.
- Tracks response ownership across the RAM's 1-cycle read latency and exposes saturating contention counters.

Parameters:
- ADDR_WIDTH, 15: RAM byte-address width; matches the wrapper's address port.
- DATA_WIDTH, 32: data width; byte enables are DATA_WIDTH/8 wide.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins except on starvation override.
- MAX_WAIT, 8: in FIXED_PRIO mode, the number of consecutive denied cycles after which port 1 is forced to win. Range 1..255.
- CNT_WIDTH, 16: width of the contention counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- p0_req_i  in  1  port 0 request.
- p0_gnt_o  out  1  port 0 grant; combinational, same cycle as request.
- p0_addr_i  in  ADDR_WIDTH  port 0 byte address.
- p0_we_i  in  1  port 0 write enable.
- p0_be_i  in  DATA_WIDTH/8  port 0 byte enables.
- p0_wdata_i  in  DATA_WIDTH  port 0 write data.
- p0_rvalid_o  out  1  port 0 response valid; asserted the cycle after its grant.
- p0_rdata_o  out  DATA_WIDTH  port 0 read data; meaningful only while p0_rvalid_o is high.
- p1_*  same set as p0_*, for port 1.
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; valid 1 cycle after ram_en_o.
- conflict_cnt_o  out  CNT_WIDTH  number of cycles in which both ports requested.
- p1_stall_cnt_o  out  CNT_WIDTH  number of cycles in which p1_req_i was high and not granted.
- clr_cnt_i  in  1  synchronous clear of both counters.

Behaviour:
- Reset values: rvalid outputs 0; owner register 0; RR pointer selects port 0 first; wait counter 0; contention counters 0. While rstn_i is low, all gnt outputs and ram_en_o are forced to 0.
- Grant (combinational):
  - Only one requester: that requester is granted.
  - Both requesting, round-robin: the port indicated by the RR pointer wins.
  - Both requesting, fixed priority: port 0 wins, unless the wait counter has reached MAX_WAIT, in which case port 1 wins.
- At most one gnt output is high in any cycle. The gnt_o of a port is never high while its req_i is low.
- RAM drive: ram_en_o = p0_gnt_o | p1_gnt_o. ram_addr/we/be/wdata are muxed from the winner. When idle, ram_we_o = 0 and ram_be_o = 0; addr/wdata hold the port 0 values.
- RR pointer: on each grant, the pointer moves to the port that did not win. No grant leaves the pointer unchanged.
- Wait counter (FIXED_PRIO only):
  - Increments, saturating at MAX_WAIT, in each cycle where p1_req_i is high and p1 is not granted.
  - Clears to 0 on a p1 grant or when p1_req_i is low.
- Response path:
  - Register valid_q <= ram_en_o and owner_q <= winner index.
  - Next cycle: px_rvalid_o = valid_q & (owner_q == x).
  - Both rdata outputs are driven from ram_rdata_i at all times.
  - Writes also produce rvalid (rdata is don't-care). Back-to-back grants give one rvalid per grant, in order, with fixed 1-cycle latency.
- A requester holds req/addr/we/be/wdata stable until granted. Dropping req before grant is legal; nothing is issued.
- Counters: saturate at all-ones. clr_cnt_i takes priority over increment in the same cycle.
- Reset asserted mid-access: the pending rvalid is dropped immediately (asynchronous clear); no response is delivered after reset release.
- Addresses pass through unmodified. Bank selection by the top address bit stays inside the RAM wrapper, so the arbiter is bank-agnostic.

Test Plan:
- Single port 0: write 0xDEADBEEF to address 0x0010 with be=0xF, then read 0x0010 -> p0_gnt same cycle; p0_rvalid 1 cycle later; p0_rdata = 0xDEADBEEF; p1_rvalid stays 0.
- Round-robin, both ports reading continuously for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1; conflict_cnt_o = 6; p1_stall_cnt_o = 3; each rvalid goes to the owning port 1 cycle after its grant.
- FIXED_PRIO=1, MAX_WAIT=4, both requesting continuously -> p0 granted 4 cycles, p1 granted on cycle 5, then p0 for 4 more cycles; p1 is never starved beyond 4 cycles.
- Bank crossing: p0 writes 0x0004 (lower bank) while p1 writes 0x4004 (upper bank), then each reads back -> both values return intact; no cross-port rdata leakage.
- Reset mid-op: assert rstn_i low the cycle after a p1 read grant -> p1_rvalid_o = 0 immediately; after release, RR pointer = port 0 and counters = 0.
- Counter saturation and clear: with CNT_WIDTH=4, run 20 conflict cycles -> conflict_cnt_o = 15; assert clr_cnt_i together with a conflict -> counter reads 0 in the next cycle.
